// File: rtl/conf_mul_pkg.sv
// Shared definitions for the configurable integer multiplier pipeline.
//   mode_e   : per-beat operand treatment (accurate / approximate-lsb / upper-chunk / reserved)
//   OP_CNT_W : width of the consumed-result counter
package conf_mul_pkg;

   typedef enum logic [1:0] {
      MODE_ACC   = 2'b00,
      MODE_APX   = 2'b01,
      MODE_UPPER = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   localparam int unsigned OP_CNT_W = 16;

endpackage

// File: rtl/conf_int_mul_core.sv
// Purely combinational full-width signed multiplier.
//   a_i, b_i : signed operands, WIDTH bits each
//   prod_o   : signed product, 2*WIDTH bits
module conf_int_mul_core #(
   parameter int WIDTH = 24
) (
   input  logic signed [WIDTH-1:0]   a_i,
   input  logic signed [WIDTH-1:0]   b_i,
   output logic signed [2*WIDTH-1:0] prod_o
);

   always_comb begin
      prod_o = a_i * b_i;
   end

endmodule

// File: rtl/conf_int_mul_pipe.sv
// Two-stage signed multiplier with per-beat approximation modes and valid/ready flow control.
// Stage 1 holds the masked operands, stage 2 holds the full product; p/ovf are a window of it.
// Optional feature: define CONF_MUL_ROUND_EN for round-half-up windowing (default truncates).
//   clk, racc_n         : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake
//   a, b                : signed operands
//   mode, apx_bits      : per-beat operand mode and LSB-zeroing count for approximate mode
//   out_valid, out_ready: output handshake
//   p, ovf              : product window and window-overflow flag
//   op_cnt              : wrapping count of consumed results
module conf_int_mul_pipe
   import conf_mul_pkg::*;
#(
   parameter int OP_BITWIDTH        = 16,
   parameter int DATA_PATH_BITWIDTH = 24,
   parameter int OUT_BITWIDTH       = 32,
   parameter int OUT_SHIFT          = 8
) (
   input  logic                                    clk,
   input  logic                                    racc_n,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic signed [DATA_PATH_BITWIDTH-1:0]    a,
   input  logic signed [DATA_PATH_BITWIDTH-1:0]    b,
   input  logic [1:0]                              mode,
   input  logic [$clog2(DATA_PATH_BITWIDTH+1)-1:0] apx_bits,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [OUT_BITWIDTH-1:0]                 p,
   output logic                                    ovf,
   output logic [OP_CNT_W-1:0]                     op_cnt
);

   localparam int DW      = DATA_PATH_BITWIDTH;
   localparam int PW      = 2 * DW;
   localparam int TOP     = OUT_SHIFT + OUT_BITWIDTH;
   localparam int RND_IDX = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

   logic                 s1_valid_q, s1_valid_d;
   logic signed [DW-1:0] s1_a_q, s1_a_d;
   logic signed [DW-1:0] s1_b_q, s1_b_d;
   logic                 s2_valid_q, s2_valid_d;
   logic signed [PW-1:0] prod_q, prod_d;
   logic [OP_CNT_W-1:0]  op_cnt_q, op_cnt_d;

   logic                 s1_adv;
   logic                 accept;
   logic                 consume;
   int                   zero_cnt;
   logic [DW-1:0]        keep_mask;

   // Handshake: stage 1 moves on when stage 2 is empty or draining this cycle.
   always_comb begin
      s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
      in_ready = !s1_valid_q || s1_adv;
      accept   = in_valid && in_ready;
      consume  = s2_valid_q && out_ready;
   end

   // Number of operand LSBs forced to zero for this beat.
   always_comb begin
      zero_cnt = 0;
      case (mode_e'(mode))
         MODE_APX:   zero_cnt = (int'(apx_bits) > DW) ? DW : int'(apx_bits);
         MODE_UPPER: zero_cnt = DW - OP_BITWIDTH;
         default:    zero_cnt = 0;
      endcase
      for (int i = 0; i < DW; i++) begin
         keep_mask[i] = (i >= zero_cnt);
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = a & keep_mask;
         s1_b_d     = b & keep_mask;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   conf_int_mul_core #(
      .WIDTH (DW)
   ) u_core (
      .a_i    (s1_a_q),
      .b_i    (s1_b_q),
      .prod_o (prod_d)
   );

   always_comb begin
      s2_valid_d = s2_valid_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
      end else if (consume) begin
         s2_valid_d = 1'b0;
      end
      op_cnt_d = consume ? op_cnt_q + OP_CNT_W'(1) : op_cnt_q;
   end

   always_ff @(posedge clk or negedge racc_n) begin
      if (!racc_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         prod_q     <= '0;
         op_cnt_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         if (s1_adv) begin
            prod_q <= prod_d;
         end
         op_cnt_q   <= op_cnt_d;
      end
   end

   // Window extraction from the held product; one extra sign bit absorbs a rounding carry.
   logic signed [PW:0] rnd_val;
   logic               unused_lsb;

   always_comb begin
      rnd_val = {prod_q[PW-1], prod_q};
`ifdef CONF_MUL_ROUND_EN
      if (OUT_SHIFT > 0) begin
         rnd_val = rnd_val + ({{PW{1'b0}}, prod_q[RND_IDX]} << OUT_SHIFT);
      end
`endif
      p   = rnd_val[OUT_SHIFT +: OUT_BITWIDTH];
      ovf = 1'b0;
      for (int i = TOP; i <= PW; i++) begin
         if (rnd_val[i] != rnd_val[TOP-1]) begin
            ovf = 1'b1;
         end
      end
      unused_lsb = 1'b0;
      for (int i = 0; i < OUT_SHIFT; i++) begin
         unused_lsb = unused_lsb ^ rnd_val[i];
      end
   end

   assign out_valid = s2_valid_q;
   assign op_cnt    = op_cnt_q;

endmodule
